multi_freq_counter: RTL and testbench
=====================================

MULTI_FREQ_COUNTER -- requirements
Module: multi_freq_counter

Interface
REQ-001 Parameter NCH, default 4: number of independent input channels.
REQ-002 Parameter CNT_W, default 10: per-channel edge-count width.
REQ-003 Parameter WINDOW_CYCLES, default 480_000: gate length in int_osc cycles (10 ms at 48 MHz); legal range 2..2^TIMER_W-1.
REQ-004 Parameter TIMER_W, default 26: gate timer width.
REQ-005 int_osc  in  1: sole clock; all flops rising-edge.
REQ-006 reset  in  1: asynchronous, active-low reset.
REQ-007 square  in  NCH: asynchronous measured signals, one bit per channel.
REQ-008 edge_sel  in  2: edge type counted: 00 falling, 01 rising, 10/11 both.
REQ-009 mode  in  1: 0 single-shot, 1 continuous.
REQ-010 start  in  1: synchronous request to begin measurement.
REQ-011 ack  in  1: consumer acknowledge of result_valid.
REQ-012 counts  out  NCH*CNT_W: latched counts; channel i at bits [i*CNT_W +: CNT_W].
REQ-013 ovf  out  NCH: latched per-channel saturation flags.
REQ-014 busy  out  1: high while a gate window is open.
REQ-015 result_valid  out  1: latched results are unread.
REQ-016 overrun  out  1: sticky; a result was overwritten while unread.

Function
REQ-017 Each square bit SHALL pass a 2-flop synchronizer plus one history flop; edges are detected from synchronized and history bits only.
REQ-018 Edge events per edge_sel: falling = hist & ~sync, rising = ~hist & sync, both = hist ^ sync.
REQ-019 FSM states SHALL be IDLE, COUNT, LATCH.
REQ-020 IDLE: start=1 SHALL move to COUNT next cycle, with timer and all channel counters cleared and edge_sel and mode captured into internal registers.
REQ-021 COUNT SHALL last exactly WINDOW_CYCLES cycles (timer 0..WINDOW_CYCLES-1); busy=1 in every COUNT cycle only.
REQ-022 Each qualifying edge in a COUNT cycle SHALL increment that channel's counter by 1, including in the cycle timer = WINDOW_CYCLES-1.
REQ-023 A counter at 2^CNT_W-1 SHALL hold (saturate) and set its internal overflow bit; no wrap-around.
REQ-024 After timer = WINDOW_CYCLES-1 the FSM SHALL enter LATCH for exactly one cycle.
REQ-025 LATCH: counts and ovf SHALL be loaded from the counters and overflow bits; result_valid set to 1.
REQ-026 Edges occurring in the LATCH or IDLE cycles SHALL NOT be counted.
REQ-027 LATCH exit: captured mode 1 -> COUNT with counters and timer cleared and edge_sel/mode recaptured; mode 0 -> IDLE.
REQ-028 start SHALL be ignored outside IDLE; edge_sel and mode changes SHALL take effect only at the next capture.
REQ-029 ack=1 SHALL clear result_valid next cycle, unless a LATCH occurs the same cycle, in which case result_valid stays 1.
REQ-030 LATCH with result_valid=1 and ack=0 SHALL set overrun; overrun clears only on reset.
REQ-031 counts and ovf SHALL hold their values between LATCH cycles.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 reset low SHALL immediately force IDLE and clear timer, counters, synchronizers, history flops and every output: counts=0, ovf=0, busy=0, result_valid=0, overrun=0.
REQ-034 reset asserted mid-window SHALL abort the window with no LATCH; after release the block stays in IDLE until start.

Verification (bench uses NCH=4, CNT_W=4, WINDOW_CYCLES=100)
REQ-035 Ch0 square period 10 cycles, edge_sel=00, mode=0, single start pulse -> busy high for 100 cycles, then counts[3:0]=10, ovf[0]=0, result_valid=1, FSM back in IDLE.
REQ-036 Same stimulus with edge_sel=10 -> counts[3:0]=15 (20 edges saturated), ovf[0]=1; ch1 idle -> counts[7:4]=0, ovf[1]=0.
REQ-037 mode=1, ack never asserted -> second LATCH sets overrun=1 and counts update; with ack pulsed after each LATCH -> overrun stays 0.
REQ-038 reset pulled low at timer=50 -> all outputs 0 asynchronously; no result_valid after release until a new start.
REQ-039 start pulsed at timer=30 -> ignored; window still ends at cycle 100 with one LATCH.
REQ-040 Edge only in LATCH cycle -> not counted; edge at timer=99 -> counted (count=1).

Source files
------------

// File: rtl/multi_freq_counter_if.sv
// Bus bundle for multi_freq_counter: measured inputs, control and latched results.
// The master side drives the inputs and reads back the results.
interface multi_freq_counter_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 10
);
  logic [NCH-1:0]       square;
  logic [1:0]           edge_sel;
  logic                 mode;
  logic                 start;
  logic                 ack;
  logic [NCH*CNT_W-1:0] counts;
  logic [NCH-1:0]       ovf;
  logic                 busy;
  logic                 result_valid;
  logic                 overrun;

  modport master (
    output square, edge_sel, mode, start, ack,
    input  counts, ovf, busy, result_valid, overrun
  );

  modport slave (
    input  square, edge_sel, mode, start, ack,
    output counts, ovf, busy, result_valid, overrun
  );
endinterface

// File: rtl/multi_freq_counter.sv
// Gated multi-channel edge counter: counts synchronized edges over a fixed window of
// int_osc cycles, then latches the per-channel counts and saturation flags.
module multi_freq_counter #(
  parameter int unsigned NCH           = 4,
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned WINDOW_CYCLES = 480_000,
  parameter int unsigned TIMER_W       = 26
) (
  input logic                int_osc,
  input logic                reset,
  multi_freq_counter_if.slave bus
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t                        state;
  logic [TIMER_W-1:0]            timer;
  logic [NCH-1:0][CNT_W-1:0]     cnt;
  logic [NCH-1:0]                ovf_int;
  logic [1:0]                    sel_q;
  logic                          mode_q;

  logic [NCH-1:0]                sync1;
  logic [NCH-1:0]                sync2;
  logic [NCH-1:0]                hist;
  logic [NCH-1:0]                edge_ev_c;

  logic [NCH-1:0][CNT_W-1:0]     counts_q;
  logic [NCH-1:0]                ovf_q;
  logic                          busy_q;
  logic                          result_valid_q;
  logic                          overrun_q;

  // Two-flop synchronizer plus history flop per channel
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= bus.square;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Edge qualification uses the edge type captured at window start
  always_comb begin
    edge_ev_c = '0;
    case (sel_q)
      2'b00:   edge_ev_c = hist & ~sync2;
      2'b01:   edge_ev_c = ~hist & sync2;
      default: edge_ev_c = hist ^ sync2;
    endcase
  end

  // Gate FSM, window counters and registered results
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      timer          <= '0;
      cnt            <= '0;
      ovf_int        <= '0;
      sel_q          <= 2'b00;
      mode_q         <= 1'b0;
      counts_q       <= '0;
      ovf_q          <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= COUNT;
            timer   <= '0;
            cnt     <= '0;
            ovf_int <= '0;
            sel_q   <= bus.edge_sel;
            mode_q  <= bus.mode;
            busy_q  <= 1'b1;
          end
        end

        COUNT: begin
          for (int i = 0; i < NCH; i++) begin
            if (edge_ev_c[i]) begin
              if (cnt[i] == CNT_MAX) begin
                ovf_int[i] <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] + CNT_W'(1);
              end
            end
          end
          if (timer == TIMER_LAST) begin
            state  <= LATCH;
            busy_q <= 1'b0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        LATCH: begin
          counts_q <= cnt;
          ovf_q    <= ovf_int;
          if (result_valid_q && !bus.ack) begin
            overrun_q <= 1'b1;
          end
          // Continuous mode re-arms immediately with freshly captured settings
          if (mode_q) begin
            state   <= COUNT;
            timer   <= '0;
            cnt     <= '0;
            ovf_int <= '0;
            sel_q   <= bus.edge_sel;
            mode_q  <= bus.mode;
            busy_q  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase

      // A LATCH wins over a concurrent ack
      if (state == LATCH) begin
        result_valid_q <= 1'b1;
      end else if (bus.ack) begin
        result_valid_q <= 1'b0;
      end
    end
  end

  assign bus.counts       = counts_q;
  assign bus.ovf          = ovf_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_multi_freq_counter.sv
// Directed bench for multi_freq_counter: expected results are queued at each window
// start and compared when the window's result is latched.
module tb_multi_freq_counter;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WIN   = 100;

  typedef struct packed {
    logic [NCH*CNT_W-1:0] counts;
    logic [NCH-1:0]       ovf;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           gen_en;
  logic           gen_sq;
  logic [NCH-1:0] man_sq;

  int   total;
  int   bad;
  exp_t sb[$];

  multi_freq_counter_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  multi_freq_counter #(
    .NCH          (NCH),
    .CNT_W        (CNT_W),
    .WINDOW_CYCLES(WIN),
    .TIMER_W      (8)
  ) dut (
    .int_osc(clk),
    .reset  (rst_n),
    .bus    (bus)
  );

  assign bus.square = man_sq | {{(NCH-1){1'b0}}, gen_sq};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running period-10 square wave on channel 0 while enabled
  initial begin
    int ph;
    ph     = 0;
    gen_sq = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!gen_en) begin
        gen_sq = 1'b0;
        ph     = 0;
      end else if (ph == 4) begin
        gen_sq = ~gen_sq;
        ph     = 0;
      end else begin
        ph++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  // Pulse start from IDLE; afterwards the bench sits in window cycle 0
  task automatic kick(input string tag, input exp_t e);
    bus.start = 1'b1;
    sb.push_back(e);
    step();
    bus.start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
  endtask

  // Advance until busy drops (LATCH cycle); exp_n is the remaining window length
  task automatic run_to_latch(input string tag, input int exp_n);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_window_len"}, 32'(n), 32'(exp_n));
  endtask

  // Step past LATCH and compare latched results with the oldest expectation
  task automatic check_result(input string tag);
    exp_t e;
    step();
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_counts"}, 32'(bus.counts), 32'(e.counts));
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
    end
    chk({tag, "_rv"}, 32'(bus.result_valid), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_counts"}, 32'(bus.counts), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rv"}, 32'(bus.result_valid), 32'd0);
    chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
  endtask

  initial begin
    int seen;
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    gen_en       = 1'b0;
    man_sq       = '0;
    bus.start    = 1'b0;
    bus.ack      = 1'b0;
    bus.edge_sel = 2'b00;
    bus.mode     = 1'b0;

    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // Falling edges, single shot: 10 edges in 100 cycles
    gen_en = 1'b1;
    repeat (20) step();
    kick("t1", '{counts: 16'h000A, ovf: 4'h0});
    run_to_latch("t1", WIN);
    check_result("t1");
    chk("t1_idle", 32'(bus.busy), 32'd0);
    step();
    chk("t1_still_idle", 32'(bus.busy), 32'd0);
    chk("t1_overrun", 32'(bus.overrun), 32'd0);
    do_ack();
    chk("t1_ack_clear", 32'(bus.result_valid), 32'd0);

    // Both edges: 20 edges saturate at 15 with overflow flag
    bus.edge_sel = 2'b10;
    kick("t2", '{counts: 16'h000F, ovf: 4'h1});
    run_to_latch("t2", WIN);
    check_result("t2");
    chk("t2_overrun", 32'(bus.overrun), 32'd0);
    do_ack();

    // Continuous, no ack: settings changed mid-window apply to the next window only
    bus.edge_sel = 2'b00;
    bus.mode     = 1'b1;
    kick("t3a", '{counts: 16'h000A, ovf: 4'h0});
    bus.edge_sel = 2'b10;
    bus.mode     = 1'b0;
    sb.push_back('{counts: 16'h000F, ovf: 4'h1});
    run_to_latch("t3a", WIN);
    check_result("t3a");
    chk("t3a_overrun", 32'(bus.overrun), 32'd0);
    chk("t3a_rearm", 32'(bus.busy), 32'd1);
    run_to_latch("t3b", WIN);
    check_result("t3b");
    chk("t3b_overrun", 32'(bus.overrun), 32'd1);
    chk("t3b_idle", 32'(bus.busy), 32'd0);

    // Reset mid-window aborts it and clears every output asynchronously
    bus.edge_sel = 2'b00;
    kick("t4", '{counts: 16'h000A, ovf: 4'h0});
    repeat (50) step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("t4_async");
    void'(sb.pop_back());
    repeat (2) step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) seen++;
    end
    chk("t4_post_reset_idle", 32'(seen), 32'd0);

    // Continuous with ack arriving in the second LATCH cycle: no overrun
    bus.mode = 1'b1;
    kick("t5a", '{counts: 16'h000A, ovf: 4'h0});
    bus.mode = 1'b0;
    sb.push_back('{counts: 16'h000A, ovf: 4'h0});
    run_to_latch("t5a", WIN);
    check_result("t5a");
    run_to_latch("t5b", WIN);
    bus.ack = 1'b1;
    check_result("t5b");
    bus.ack = 1'b0;
    chk("t5b_overrun", 32'(bus.overrun), 32'd0);
    do_ack();
    chk("t5_ack_clear", 32'(bus.result_valid), 32'd0);

    // start mid-window is ignored: one window, one LATCH
    kick("t6", '{counts: 16'h000A, ovf: 4'h0});
    repeat (30) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_to_latch("t6", WIN - 31);
    check_result("t6");
    repeat (5) step();
    chk("t6_single_latch", 32'(bus.busy), 32'd0);
    do_ack();

    // Rising edge on ch1 visible only in the LATCH cycle is dropped
    gen_en = 1'b0;
    bus.edge_sel = 2'b01;
    repeat (3) step();
    kick("t7a", '{counts: 16'h0000, ovf: 4'h0});
    repeat (98) step();
    man_sq[1] = 1'b1;
    run_to_latch("t7a", 2);
    check_result("t7a");
    man_sq[1] = 1'b0;
    do_ack();
    repeat (4) step();

    // Rising edge visible at the last timer value is counted
    kick("t7b", '{counts: 16'h0010, ovf: 4'h0});
    repeat (97) step();
    man_sq[1] = 1'b1;
    run_to_latch("t7b", 3);
    check_result("t7b");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
